display_scan_receiver: RTL and testbench



---
 rtl/display_scan_receiver_pkg.sv | 44 ++++
 rtl/display_scan_receiver_seg7_decoder.sv | 37 +++
 rtl/display_scan_receiver.sv | 176 +++++++++++++++++
 tb/tb_display_scan_receiver.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/display_scan_receiver_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Package     : display_scan_receiver_pkg                              |
// | Description : Shared constants for the 7-segment scan receiver:      |
// |               active-low hex segment patterns (seg[6]=a..seg[0]=g),  |
// |               the blank pattern and the FSM state encodings.         |
// | Revision    : 1.0  initial release                                   |
// +----------------------------------------------------------------------+
package display_scan_receiver_pkg;

  // All segments off (active-low cathodes).
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  // Receiver FSM state encodings.
  localparam logic [0:0] STATE_HUNT     = 1'b0;
  localparam logic [0:0] STATE_ASSEMBLE = 1'b1;

  // Hex nibble to active-low segment pattern; identical to the encoder
  // on the driving side so the decoder is its exact inverse.
  function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
    logic [6:0] pat;
    case (nib)
      4'h0:    pat = 7'b0000001;
      4'h1:    pat = 7'b1001111;
      4'h2:    pat = 7'b0010010;
      4'h3:    pat = 7'b0000110;
      4'h4:    pat = 7'b1001100;
      4'h5:    pat = 7'b0100100;
      4'h6:    pat = 7'b0100000;
      4'h7:    pat = 7'b0001111;
      4'h8:    pat = 7'b0000000;
      4'h9:    pat = 7'b0000100;
      4'hA:    pat = 7'b0001000;
      4'hB:    pat = 7'b1100000;
      4'hC:    pat = 7'b0110001;
      4'hD:    pat = 7'b1000010;
      4'hE:    pat = 7'b0110000;
      default: pat = 7'b0111000;
    endcase
    return pat;
  endfunction

endpackage
`default_nettype wire

// File: rtl/display_scan_receiver_seg7_decoder.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : display_scan_receiver_seg7_decoder                     |
// | Description : Combinational inverse of the hex-to-7-segment encoder. |
// | Revision    : 1.0  initial release                                   |
// | Ports       : seg_i   [6:0] active-low cathode pattern               |
// |               nib_o   [3:0] decoded hex nibble (0 when invalid)      |
// |               valid_o       pattern is a legal hex (or blank) code   |
// +----------------------------------------------------------------------+
module display_scan_receiver_seg7_decoder
  import display_scan_receiver_pkg::*;
#(
  parameter bit ALLOW_BLANK = 1'b0
) (
  input  logic [6:0] seg_i,
  output logic [3:0] nib_o,
  output logic       valid_o
);

  always_comb begin
    nib_o   = 4'h0;
    valid_o = 1'b0;
    for (int i = 0; i < 16; i++) begin
      if (seg_i == hex_to_seg(4'(i))) begin
        nib_o   = 4'(i);
        valid_o = 1'b1;
      end
    end
    // The blank pattern never collides with a hex pattern.
    if (ALLOW_BLANK && (seg_i == SEG_BLANK)) begin
      nib_o   = 4'h0;
      valid_o = 1'b1;
    end
  end

endmodule
`default_nettype wire

// File: rtl/display_scan_receiver.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : display_scan_receiver                                  |
// | Description : Monitors a multiplexed 8-digit 7-segment scan bus,     |
// |               checks strobe/code legality and reassembles the shown  |
// |               32-bit word.                                           |
// | Revision    : 1.0  initial release                                   |
// | Ports       : clk_480Hz         scan clock, one digit per edge       |
// |               reset             asynchronous, active-high            |
// |               anode   [7:0]     active-low digit enables             |
// |               seg_sel [2:0]     digit index with the strobe          |
// |               seg     [6:0]     active-low cathodes                  |
// |               data_out[31:0]    last complete frame                  |
// |               frame_valid       pulse when data_out updates          |
// |               locked            frame lock status                    |
// |               strobe_err        pulse on anode/seg_sel violation     |
// |               code_err          pulse on undecodable cathodes        |
// |               err_count[7:0]    saturating error-cycle count         |
// +----------------------------------------------------------------------+
module display_scan_receiver
  import display_scan_receiver_pkg::*;
#(
  parameter bit ALLOW_BLANK = 1'b0,
  parameter bit CHECK_SEL   = 1'b1
) (
  input  logic        clk_480Hz,
  input  logic        reset,
  input  logic [7:0]  anode,
  input  logic [2:0]  seg_sel,
  input  logic [6:0]  seg,
  output logic [31:0] data_out,
  output logic        frame_valid,
  output logic        locked,
  output logic        strobe_err,
  output logic        code_err,
  output logic [7:0]  err_count
);

  // Stage 1: input sample registers.
  logic [7:0] anode_q;
  logic [2:0] seg_sel_q;
  logic [6:0] seg_q;
  // The reset-value sample is not a real observation; without this flag
  // the idle anodes left by reset would be flagged on the first edge.
  logic       primed_q;

  always_ff @(posedge clk_480Hz or posedge reset) begin
    if (reset) begin
      anode_q   <= 8'hFF;
      seg_sel_q <= 3'd0;
      seg_q     <= 7'h7F;
      primed_q  <= 1'b0;
    end else begin
      anode_q   <= anode;
      seg_sel_q <= seg_sel;
      seg_q     <= seg;
      primed_q  <= 1'b1;
    end
  end

  // Stage 2: strobe legality and index extraction.
  logic [7:0] low;
  logic       onehot;
  logic [2:0] idx;
  logic       strobe_ok;
  logic [3:0] nib;
  logic       code_ok;
  logic       good;

  always_comb begin
    low    = ~anode_q;
    onehot = (low != 8'd0) && ((low & (low - 8'd1)) == 8'd0);
    idx    = 3'd0;
    for (int k = 0; k < 8; k++) begin
      if (low[k]) idx = 3'(k);
    end
    strobe_ok = onehot && (!CHECK_SEL || (seg_sel_q == idx));
  end

  display_scan_receiver_seg7_decoder #(
    .ALLOW_BLANK (ALLOW_BLANK)
  ) u_dec (
    .seg_i   (seg_q),
    .nib_o   (nib),
    .valid_o (code_ok)
  );

  assign good = strobe_ok && code_ok;

  // Frame assembly state.
  logic [0:0]  state_q,  state_d;
  logic [2:0]  exp_q,    exp_d;
  logic [31:0] shadow_q, shadow_d;
  logic [31:0] data_q,   data_d;
  logic        fv_q,     fv_d;
  logic        locked_q, locked_d;
  logic        serr_q,   serr_d;
  logic        cerr_q,   cerr_d;
  logic [7:0]  cnt_q,    cnt_d;

  always_comb begin
    state_d  = state_q;
    exp_d    = exp_q;
    shadow_d = shadow_q;
    data_d   = data_q;
    fv_d     = 1'b0;
    locked_d = locked_q;
    serr_d   = 1'b0;
    cerr_d   = 1'b0;
    cnt_d    = cnt_q;
    if (primed_q) begin
      serr_d = !strobe_ok;
      cerr_d = !code_ok;
      if ((serr_d || cerr_d) && (cnt_q != 8'hFF)) cnt_d = cnt_q + 8'd1;

      if (state_q == STATE_HUNT) begin
        if (good && (idx == 3'd0)) begin
          shadow_d[3:0] = nib;
          exp_d         = 3'd1;
          state_d       = STATE_ASSEMBLE;
        end
      end else if (good && (idx == exp_q)) begin
        shadow_d[{exp_q, 2'b00} +: 4] = nib;
        exp_d = exp_q + 3'd1;           // wraps 7 -> 0 at frame end
        if (idx == 3'd7) begin
          data_d   = shadow_d;
          fv_d     = 1'b1;
          locked_d = 1'b1;
        end
      end else begin
        locked_d = 1'b0;
        // A legal digit-0 sample starts a fresh frame without a HUNT cycle.
        if (good && (idx == 3'd0)) begin
          shadow_d[3:0] = nib;
          exp_d         = 3'd1;
        end else begin
          state_d = STATE_HUNT;
          exp_d   = 3'd0;
        end
      end
    end
  end

  always_ff @(posedge clk_480Hz or posedge reset) begin
    if (reset) begin
      state_q  <= STATE_HUNT;
      exp_q    <= 3'd0;
      shadow_q <= 32'd0;
      data_q   <= 32'd0;
      fv_q     <= 1'b0;
      locked_q <= 1'b0;
      serr_q   <= 1'b0;
      cerr_q   <= 1'b0;
      cnt_q    <= 8'd0;
    end else begin
      state_q  <= state_d;
      exp_q    <= exp_d;
      shadow_q <= shadow_d;
      data_q   <= data_d;
      fv_q     <= fv_d;
      locked_q <= locked_d;
      serr_q   <= serr_d;
      cerr_q   <= cerr_d;
      cnt_q    <= cnt_d;
    end
  end

  assign data_out    = data_q;
  assign frame_valid = fv_q;
  assign locked      = locked_q;
  assign strobe_err  = serr_q;
  assign code_err    = cerr_q;
  assign err_count   = cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_display_scan_receiver.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : tb_display_scan_receiver                               |
// | Description : Self-checking bench for display_scan_receiver. Two     |
// |               instances share the bus: dut0 (ALLOW_BLANK=0,          |
// |               CHECK_SEL=1) and dut1 (ALLOW_BLANK=1, CHECK_SEL=0).    |
// | Revision    : 1.0  initial release                                   |
// +----------------------------------------------------------------------+
module tb_display_scan_receiver;

  logic        clk_480Hz = 1'b0;
  logic        reset     = 1'b0;
  logic [7:0]  anode     = 8'hFF;
  logic [2:0]  seg_sel   = 3'd0;
  logic [6:0]  seg       = 7'h7F;

  logic [31:0] data0, data1;
  logic        fv0, fv1, lk0, lk1, se0, se1, ce0, ce1;
  logic [7:0]  cnt0, cnt1;

  always #5 clk_480Hz = ~clk_480Hz;

  display_scan_receiver #(.ALLOW_BLANK(1'b0), .CHECK_SEL(1'b1)) dut0 (
    .clk_480Hz(clk_480Hz), .reset(reset), .anode(anode), .seg_sel(seg_sel), .seg(seg),
    .data_out(data0), .frame_valid(fv0), .locked(lk0), .strobe_err(se0),
    .code_err(ce0), .err_count(cnt0));

  display_scan_receiver #(.ALLOW_BLANK(1'b1), .CHECK_SEL(1'b0)) dut1 (
    .clk_480Hz(clk_480Hz), .reset(reset), .anode(anode), .seg_sel(seg_sel), .seg(seg),
    .data_out(data1), .frame_valid(fv1), .locked(lk1), .strobe_err(se1),
    .code_err(ce1), .err_count(cnt1));

  logic [43:0] obs0, obs1;
  assign obs0 = {data0, fv0, lk0, se0, ce0, cnt0};
  assign obs1 = {data1, fv1, lk1, se1, ce1, cnt1};

  int checks   = 0;
  int failures = 0;

  // Standard active-low hex patterns, a..g = bit6..bit0.
  logic [6:0] tb_hex [16] = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
                              7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
                              7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
                              7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000};

  // Reference model: per instance, "assembling" flag, next digit wanted,
  // the nibbles collected so far, and the expected outputs.
  bit          m_asm  [2];
  int          m_want [2];
  logic [3:0]  m_nib  [2][8];
  logic [31:0] m_data [2];
  bit          m_fv [2], m_lk [2], m_se [2], m_ce [2];
  int          m_cnt [2];
  bit          primed;
  logic [7:0]  p_an;
  logic [2:0]  p_sel;
  logic [6:0]  p_seg;
  int          scan_pos = 0;

  function automatic logic [43:0] exp_vec(input int m);
    return {m_data[m], m_fv[m], m_lk[m], m_se[m], m_ce[m], 8'(m_cnt[m])};
  endfunction

  task automatic model_reset();
    for (int m = 0; m < 2; m++) begin
      m_asm[m] = 0; m_want[m] = 0; m_data[m] = '0; m_fv[m] = 0; m_lk[m] = 0;
      m_se[m] = 0; m_ce[m] = 0; m_cnt[m] = 0;
      for (int k = 0; k < 8; k++) m_nib[m][k] = '0;
    end
    primed = 0;
  endtask

  task automatic model_apply(input int m, input logic [7:0] an, input logic [2:0] sel,
                             input logic [6:0] sg);
    int lows, idx;
    bit s_ok, c_ok, good;
    logic [3:0] nb;
    lows = 0; idx = 0;
    for (int k = 0; k < 8; k++) if (!an[k]) begin lows++; idx = k; end
    s_ok = (lows == 1) && ((m == 1) || (int'(sel) == idx));
    c_ok = 0; nb = '0;
    for (int v = 0; v < 16; v++) if (sg == tb_hex[v]) begin c_ok = 1; nb = 4'(v); end
    if ((m == 1) && (sg == 7'h7F)) begin c_ok = 1; nb = '0; end
    good = s_ok && c_ok;
    m_se[m] = !s_ok; m_ce[m] = !c_ok; m_fv[m] = 0;
    if ((!s_ok || !c_ok) && m_cnt[m] < 255) m_cnt[m]++;
    if (!m_asm[m]) begin
      if (good && idx == 0) begin m_nib[m][0] = nb; m_want[m] = 1; m_asm[m] = 1; end
    end else if (good && idx == m_want[m]) begin
      m_nib[m][idx] = nb;
      m_want[m] = (m_want[m] + 1) % 8;
      if (idx == 7) begin
        for (int k = 0; k < 8; k++) m_data[m][4*k +: 4] = m_nib[m][k];
        m_fv[m] = 1; m_lk[m] = 1;
      end
    end else begin
      m_lk[m] = 0;
      if (good && idx == 0) begin m_nib[m][0] = nb; m_want[m] = 1; end
      else begin m_asm[m] = 0; m_want[m] = 0; end
    end
  endtask

  // Drive one sample, clock it in, advance the model, settle 1 time unit.
  task automatic step(input logic [7:0] an, input logic [2:0] sel, input logic [6:0] sg);
    anode = an; seg_sel = sel; seg = sg;
    @(posedge clk_480Hz);
    if (primed) begin
      model_apply(0, p_an, p_sel, p_seg);
      model_apply(1, p_an, p_sel, p_seg);
    end
    p_an = an; p_sel = sel; p_seg = sg; primed = 1;
    #1;
  endtask

  task automatic scan_next(input logic [31:0] w);
    step(~(8'h01 << scan_pos), 3'(scan_pos), tb_hex[w[4*scan_pos +: 4]]);
    scan_pos = (scan_pos + 1) % 8;
  endtask

  task automatic test_reset();
    reset = 1'b0; #1; reset = 1'b1; model_reset();
    #10;
    checks += 2;
    if (obs0 !== 44'd0) begin failures++; $display("FAIL reset0 got %h want 0", obs0); end
    if (obs1 !== 44'd0) begin failures++; $display("FAIL reset1 got %h want 0", obs1); end
    #1; reset = 1'b0;
  endtask

  task automatic test_first_frame();
    for (int d = 0; d < 8; d++) begin
      scan_next(32'h1234ABCD);
      checks++;
      if (fv0 !== 1'b0) begin failures++; $display("FAIL early_fv d=%0d got %b want 0", d, fv0); end
    end
    scan_next(32'h1234ABCD);
    checks += 6;
    if (fv0 !== 1'b1) begin failures++; $display("FAIL first_fv got %b want 1", fv0); end
    if (data0 !== 32'h1234ABCD) begin failures++; $display("FAIL first_data got %h want 1234abcd", data0); end
    if (lk0 !== 1'b1) begin failures++; $display("FAIL first_locked got %b want 1", lk0); end
    if (cnt0 !== 8'd0) begin failures++; $display("FAIL first_cnt got %0d want 0", cnt0); end
    if (obs0 !== exp_vec(0)) begin failures++; $display("FAIL first_model0 got %h want %h", obs0, exp_vec(0)); end
    if (obs1 !== exp_vec(1)) begin failures++; $display("FAIL first_model1 got %h want %h", obs1, exp_vec(1)); end
  endtask

  task automatic test_continuous();
    int pulses = 0, unlocked = 0;
    for (int c = 0; c < 80; c++) begin
      scan_next(c < 36 ? 32'h1234ABCD : 32'hDEADBEEF);
      if (fv0) pulses++;
      if (!lk0) unlocked++;
      checks += 2;
      if (obs0 !== exp_vec(0)) begin failures++; $display("FAIL cont_model0 c=%0d got %h want %h", c, obs0, exp_vec(0)); end
      if (obs1 !== exp_vec(1)) begin failures++; $display("FAIL cont_model1 c=%0d got %h want %h", c, obs1, exp_vec(1)); end
    end
    checks += 3;
    if (pulses != 10) begin failures++; $display("FAIL cont_pulses got %0d want 10", pulses); end
    if (unlocked != 0) begin failures++; $display("FAIL cont_locked got %0d unlocked cycles want 0", unlocked); end
    if (data0 !== 32'hDEADBEEF) begin failures++; $display("FAIL cont_data got %h want deadbeef", data0); end
  endtask

  task automatic test_double_anode();
    while (scan_pos != 2) scan_next(32'hDEADBEEF);
    step(8'b11110011, 3'd2, tb_hex[4'hB]);
    scan_pos = 3;
    scan_next(32'hDEADBEEF);
    checks += 5;
    if (se0 !== 1'b1) begin failures++; $display("FAIL dbl_serr got %b want 1", se0); end
    if (lk0 !== 1'b0) begin failures++; $display("FAIL dbl_locked got %b want 0", lk0); end
    if (cnt0 !== 8'd1) begin failures++; $display("FAIL dbl_cnt got %0d want 1", cnt0); end
    if (data0 !== 32'hDEADBEEF) begin failures++; $display("FAIL dbl_data got %h want deadbeef", data0); end
    if (obs1 !== exp_vec(1)) begin failures++; $display("FAIL dbl_model1 got %h want %h", obs1, exp_vec(1)); end
    scan_next(32'hDEADBEEF);
    checks++;
    if (se0 !== 1'b0) begin failures++; $display("FAIL dbl_pulse got %b want 0", se0); end
    for (int c = 0; c < 16; c++) begin
      scan_next(32'hDEADBEEF);
      checks++;
      if (obs0 !== exp_vec(0)) begin failures++; $display("FAIL dbl_model0 c=%0d got %h want %h", c, obs0, exp_vec(0)); end
    end
    checks++;
    if (lk0 !== 1'b1) begin failures++; $display("FAIL dbl_relock got %b want 1", lk0); end
  endtask

  task automatic test_check_sel();
    while (scan_pos != 5) scan_next(32'hDEADBEEF);
    step(~8'b0010_0000, 3'd4, tb_hex[4'hA]);
    scan_pos = 6;
    scan_next(32'hDEADBEEF);
    checks += 3;
    if (se0 !== 1'b1) begin failures++; $display("FAIL sel_chk got %b want 1", se0); end
    if (se1 !== 1'b0) begin failures++; $display("FAIL sel_nochk got %b want 0", se1); end
    if (lk1 !== 1'b1) begin failures++; $display("FAIL sel_nochk_lock got %b want 1", lk1); end
    for (int c = 0; c < 16; c++) begin
      scan_next(32'hDEADBEEF);
      checks += 2;
      if (obs0 !== exp_vec(0)) begin failures++; $display("FAIL sel_model0 c=%0d got %h want %h", c, obs0, exp_vec(0)); end
      if (obs1 !== exp_vec(1)) begin failures++; $display("FAIL sel_model1 c=%0d got %h want %h", c, obs1, exp_vec(1)); end
    end
  endtask

  task automatic test_blank();
    bit seen = 0;
    while (scan_pos != 3) scan_next(32'hDEADBEEF);
    step(~8'b0000_1000, 3'd3, 7'b1111111);
    scan_pos = 4;
    scan_next(32'hDEADBEEF);
    checks += 3;
    if (ce0 !== 1'b1) begin failures++; $display("FAIL blank_cerr0 got %b want 1", ce0); end
    if (ce1 !== 1'b0) begin failures++; $display("FAIL blank_cerr1 got %b want 0", ce1); end
    if (lk0 !== 1'b0) begin failures++; $display("FAIL blank_lock0 got %b want 0", lk0); end
    for (int c = 0; c < 16 && !seen; c++) begin
      scan_next(32'hDEADBEEF);
      if (fv1) seen = 1;
    end
    checks += 2;
    if (!seen) begin failures++; $display("FAIL blank_fv1 got none want pulse within 16 cycles"); end
    if (data1 !== 32'hDEAD0EEF) begin failures++; $display("FAIL blank_data1 got %h want dead0eef", data1); end
  endtask

  task automatic test_idle_saturate();
    for (int c = 0; c < 300; c++) begin
      step(8'hFF, 3'd0, 7'h7F);
      checks += 2;
      if (obs0 !== exp_vec(0)) begin failures++; $display("FAIL idle_model0 c=%0d got %h want %h", c, obs0, exp_vec(0)); end
      if (obs1 !== exp_vec(1)) begin failures++; $display("FAIL idle_model1 c=%0d got %h want %h", c, obs1, exp_vec(1)); end
    end
    checks += 2;
    if (cnt0 !== 8'd255) begin failures++; $display("FAIL sat_cnt0 got %0d want 255", cnt0); end
    if (cnt1 !== 8'd255) begin failures++; $display("FAIL sat_cnt1 got %0d want 255", cnt1); end
  endtask

  task automatic test_reset_midframe();
    scan_pos = 0;
    for (int d = 0; d < 12; d++) scan_next(32'h0F1E2D3C);
    #2; reset = 1'b1; model_reset();
    #1;
    checks += 2;
    if (obs0 !== 44'd0) begin failures++; $display("FAIL midrst0 got %h want 0", obs0); end
    if (obs1 !== 44'd0) begin failures++; $display("FAIL midrst1 got %h want 0", obs1); end
    #2; reset = 1'b0;
    scan_pos = 0;
    for (int d = 0; d < 9; d++) scan_next(32'h7654FEDC);
    checks += 3;
    if (fv0 !== 1'b1) begin failures++; $display("FAIL rst_fv got %b want 1", fv0); end
    if (data0 !== 32'h7654FEDC) begin failures++; $display("FAIL rst_data got %h want 7654fedc", data0); end
    if (lk0 !== 1'b1 || cnt0 !== 8'd0) begin failures++; $display("FAIL rst_lock got %b/%0d want 1/0", lk0, cnt0); end
  endtask

  task automatic test_random();
    logic [31:0] rw = 32'h0;
    for (int c = 0; c < 400; c++) begin
      int r = $urandom_range(0, 9);
      if (scan_pos == 0) rw = $urandom;
      if (r < 7) scan_next(rw);
      else if (r == 7) begin
        step(($urandom_range(0, 3) == 0) ? 8'($urandom) : ~(8'h01 << $urandom_range(0, 7)),
             3'($urandom), tb_hex[$urandom_range(0, 15)]);
      end else if (r == 8) begin
        step(~(8'h01 << scan_pos), 3'(scan_pos), 7'($urandom));
        scan_pos = (scan_pos + 1) % 8;
      end else scan_pos = $urandom_range(0, 7);
      checks += 2;
      if (obs0 !== exp_vec(0)) begin failures++; $display("FAIL rand_model0 c=%0d got %h want %h", c, obs0, exp_vec(0)); end
      if (obs1 !== exp_vec(1)) begin failures++; $display("FAIL rand_model1 c=%0d got %h want %h", c, obs1, exp_vec(1)); end
    end
  endtask

  initial begin
    test_reset();
    test_first_frame();
    test_continuous();
    test_double_anode();
    test_check_sel();
    test_blank();
    test_idle_saturate();
    test_reset_midframe();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
